// File: rtl/shift_window_pkg.sv
// Shared defaults, legal parameter ranges and counter-width helpers for the
// sliding-window shift buffer.
package shift_window_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAPS   = 6;
    localparam int DEF_STRIDE = 1;

    localparam int TAPS_MIN   = 2;
    localparam int TAPS_MAX   = 16;
    localparam int STRIDE_MIN = 1;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic bit params_ok(input int taps, input int stride);
        return (taps >= TAPS_MIN) && (taps <= TAPS_MAX) &&
               (stride >= STRIDE_MIN) && (stride <= taps);
    endfunction

endpackage

// File: rtl/shift_window_path_tap_chain.sv
// TAPS x DATA_W shift register: tap 0 takes the new word, tap k takes tap k-1.
// Shifts only when enabled; a synchronous zero flushes every tap.
module shift_tap_chain
    import shift_window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_zero,
    input  logic                     i_shift,
    input  logic [DATA_W-1:0]        i_data,
    output logic [TAPS*DATA_W-1:0]   o_taps
);

    logic [DATA_W-1:0] r_taps [TAPS];

    // NOTE: the tap array is reset explicitly because the window must read as
    // all-zero after reset; use '<=' only here so every tap sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
        end else if (i_zero) begin
            for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
        end else if (i_shift) begin
            r_taps[0] <= i_data;
            for (int k = 1; k < TAPS; k++) r_taps[k] <= r_taps[k-1];
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_flat
        assign o_taps[g*DATA_W +: DATA_W] = r_taps[g];
    end

endmodule

// File: rtl/shift_window_path.sv
// Sliding-window buffer: collects pixel words into a TAPS-wide window and
// presents it in parallel, with stride, row-boundary and handshake control.
module shift_window_path
    import shift_window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int STRIDE = DEF_STRIDE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAPS*DATA_W-1:0]   w_out,
    output logic                     out_last,
    output logic                     short_row
);

    localparam int FILL_W = cnt_width(TAPS);
    localparam int STR_W  = cnt_width(STRIDE);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);
    localparam logic [STR_W-1:0]  STR_TERM  = STR_W'(STRIDE);

    if (!params_ok(TAPS, STRIDE)) begin : g_bad_params
        $error("shift_window_path: TAPS must be 2..16 and STRIDE 1..TAPS");
    end

    logic [FILL_W-1:0] r_fill;
    logic [STR_W-1:0]  r_stride_cnt;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_short_row;

    logic              w_accept;
    logic              w_in_ready;
    logic [FILL_W-1:0] w_fill_after;
    logic              w_full_after;
    logic              w_first;
    logic              w_stride_hit;
    logic              w_emit;
    logic [STR_W-1:0]  w_stride_next;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready && !clr;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_fill_after  = r_fill;
        w_full_after  = 1'b0;
        w_first       = 1'b0;
        w_stride_hit  = 1'b0;
        w_emit        = 1'b0;
        w_stride_next = r_stride_cnt;

        if (r_fill != FILL_FULL) begin
            w_fill_after = r_fill + FILL_W'(1);
            w_first      = 1'b1;
        end
        w_full_after = (w_fill_after == FILL_FULL);
        w_stride_hit = ((r_stride_cnt + STR_W'(1)) == STR_TERM);
        w_emit       = w_accept && w_full_after && (w_first || w_stride_hit);

        // Only accepts made while already full advance the stride count.
        if (w_emit) begin
            w_stride_next = '0;
        end else if (w_accept && !w_first) begin
            w_stride_next = r_stride_cnt + STR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill       <= '0;
            r_stride_cnt <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_short_row  <= 1'b0;
        end else if (clr) begin
            r_fill       <= '0;
            r_stride_cnt <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_short_row  <= 1'b0;
        end else begin
            if (w_accept) begin
                // A row end restarts the fill so windows never straddle rows.
                if (in_last) begin
                    r_fill       <= '0;
                    r_stride_cnt <= '0;
                end else begin
                    r_fill       <= w_fill_after;
                    r_stride_cnt <= w_stride_next;
                end
            end

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_last  <= in_last;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            r_short_row <= w_accept && in_last && !w_full_after;
        end
    end

    shift_tap_chain #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_tap_chain (
        .clk     (clk),
        .reset   (reset),
        .i_zero  (clr),
        .i_shift (w_accept),
        .i_data  (data_in),
        .o_taps  (w_out)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign short_row = r_short_row;

endmodule

// File: tb/tb_shift_window_path.sv
// Directed bench for shift_window_path: default (STRIDE=1) and STRIDE=3 builds.
module tb_shift_window_path;

    localparam int DW = 32;
    localparam int NT = 6;
    localparam int WW = DW * NT;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr, in_valid, in_last, out_ready;
    logic [DW-1:0] data_in;
    logic          in_ready, out_valid, out_last, short_row;
    logic [WW-1:0] w_out;

    logic          s_clr, s_in_valid, s_in_last, s_out_ready;
    logic [DW-1:0] s_data_in;
    logic          s_in_ready, s_out_valid, s_out_last, s_short_row;
    logic [WW-1:0] s_w_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_window_path #(.DATA_W(DW), .TAPS(NT), .STRIDE(1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w_out     (w_out),
        .out_last  (out_last),
        .short_row (short_row)
    );

    shift_window_path #(.DATA_W(DW), .TAPS(NT), .STRIDE(3)) u_dut_s3 (
        .clk       (clk),
        .reset     (reset),
        .clr       (s_clr),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .data_in   (s_data_in),
        .in_last   (s_in_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .w_out     (s_w_out),
        .out_last  (s_out_last),
        .short_row (s_short_row)
    );

    // Window whose tap 0 is 'newest' and tap k is newest-k.
    function automatic logic [WW-1:0] win(input int newest);
        logic [WW-1:0] v;
        v = '0;
        for (int k = 0; k < NT; k++) v[k*DW +: DW] = DW'(newest - k);
        return v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic last);
        in_valid = 1'b1;
        data_in  = DW'(d);
        in_last  = last;
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear(input int d);
        clr      = 1'b1;
        in_valid = 1'b1;
        data_in  = DW'(d);
        cycle();
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic s_push(input int d);
        s_in_valid = 1'b1;
        s_data_in  = DW'(d);
        cycle();
        s_in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        data_in = '0; out_ready = 1'b1;
        s_clr = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0;
        s_data_in = '0; s_out_ready = 1'b1;

        // Reset values
        #12;
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_win("rst_w_out", w_out, '0);
        check_bit("rst_out_last", out_last, 1'b0);
        check_bit("rst_short_row", short_row, 1'b0);
        check_bit("rst_s3_out_valid", s_out_valid, 1'b0);
        cycle();
        reset = 1'b0;

        // Back-to-back words 1..7 with out_ready held high
        for (int w = 1; w <= 7; w++) begin
            push(w, 1'b0);
            check_bit($sformatf("fill_valid_%0d", w), out_valid, (w >= 6));
            if (w >= 6) check_win($sformatf("fill_win_%0d", w), w_out, win(w));
        end
        cycle();
        check_bit("fill_drained", out_valid, 1'b0);

        // Backpressure: window 1..6 held while in_valid stays up
        clear(99);
        check_bit("bp_clr_valid", out_valid, 1'b0);
        check_win("bp_clr_wout", w_out, '0);
        out_ready = 1'b0;
        for (int w = 1; w <= 6; w++) push(w, 1'b0);
        check_bit("bp_valid", out_valid, 1'b1);
        check_bit("bp_in_ready_low", in_ready, 1'b0);
        in_valid = 1'b1;
        data_in  = DW'(7);
        for (int c = 0; c < 5; c++) begin
            cycle();
            check_win($sformatf("bp_hold_%0d", c), w_out, win(6));
            check_bit($sformatf("bp_stall_%0d", c), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check_bit("bp_in_ready_high", in_ready, 1'b1);
        cycle();
        check_bit("bp_valid_7", out_valid, 1'b1);
        check_win("bp_win_7", w_out, win(7));
        data_in = DW'(8);
        cycle();
        check_win("bp_win_8", w_out, win(8));
        in_valid = 1'b0;
        cycle();
        check_bit("bp_drained", out_valid, 1'b0);

        // Row end on word 8, then a fresh row 9..14
        clear(0);
        for (int w = 1; w <= 8; w++) begin
            push(w, (w == 8));
            check_bit($sformatf("row_valid_%0d", w), out_valid, (w >= 6));
            if (w >= 6) begin
                check_win($sformatf("row_win_%0d", w), w_out, win(w));
                check_bit($sformatf("row_last_%0d", w), out_last, (w == 8));
            end
        end
        check_bit("row_no_short", short_row, 1'b0);
        for (int w = 9; w <= 14; w++) begin
            push(w, 1'b0);
            check_bit($sformatf("row2_valid_%0d", w), out_valid, (w == 14));
        end
        check_win("row2_win_14", w_out, win(14));
        check_bit("row2_last", out_last, 1'b0);

        // Short row: in_last on word 4
        clear(0);
        for (int w = 1; w <= 3; w++) push(w, 1'b0);
        push(4, 1'b1);
        check_bit("short_pulse", short_row, 1'b1);
        check_bit("short_no_valid", out_valid, 1'b0);
        cycle();
        check_bit("short_pulse_end", short_row, 1'b0);
        for (int w = 5; w <= 10; w++) begin
            push(w, 1'b0);
            check_bit($sformatf("short_next_valid_%0d", w), out_valid, (w == 10));
        end
        check_win("short_next_win", w_out, win(10));

        // Asynchronous reset with fill = 3
        clear(0);
        for (int w = 1; w <= 3; w++) push(w, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_win("areset_wout", w_out, '0);
        check_bit("areset_valid", out_valid, 1'b0);
        check_bit("areset_in_ready", in_ready, 1'b1);
        check_bit("areset_short", short_row, 1'b0);
        cycle();
        reset = 1'b0;
        for (int w = 4; w <= 9; w++) begin
            push(w, 1'b0);
            check_bit($sformatf("areset_valid_%0d", w), out_valid, (w == 9));
        end
        check_win("areset_win_9", w_out, win(9));

        // clr with a simultaneous word: the word must be dropped
        clear(55);
        check_bit("clr_valid", out_valid, 1'b0);
        check_win("clr_wout", w_out, '0);
        check_bit("clr_last", out_last, 1'b0);
        check_bit("clr_short", short_row, 1'b0);
        for (int w = 20; w <= 25; w++) begin
            push(w, 1'b0);
            check_bit($sformatf("clr_valid_%0d", w), out_valid, (w == 25));
        end
        check_win("clr_win_25", w_out, win(25));

        // STRIDE=3 build: windows at 6, 9, 12 only
        for (int w = 1; w <= 12; w++) begin
            s_push(w);
            check_bit($sformatf("s3_valid_%0d", w), s_out_valid,
                      (w == 6) || (w == 9) || (w == 12));
            if ((w == 6) || (w == 9) || (w == 12))
                check_win($sformatf("s3_win_%0d", w), s_w_out, win(w));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
